// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//    Arbitrates two writeback requesters onto the single write port of a
//    register file. It keeps a pending-writeback scoreboard for issued
//    instructions and produces read-after-write hazard flags for two source
//    operands.
//
// Optional feature (compile-time macro):
//    WBARB_RR_EN
//       Defined:   round-robin arbitration with a 1-bit last-grant pointer.
//       Undefined: fixed priority, where port 0 always wins on contention.
//
// Parameters:
//    DW  write-data width
//    AW  register address width (2**AW registers)
//
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    p0_valid/ready/addr/data   requester 0 writeback handshake
//    p1_valid/ready/addr/data   requester 1 writeback handshake
//    RegWrite, wr, wd           registered register-file write port
//    iss_valid, iss_rd          issued instruction with a destination register
//    chk_a, chk_b               source registers to hazard-check
//    hz_a, hz_b                 combinational hazard flags
//    pend                       scoreboard of outstanding writebacks
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic               clk,
   input  logic               rst_n,

   input  logic               p0_valid,
   output logic               p0_ready,
   input  logic [AW-1:0]      p0_addr,
   input  logic [DW-1:0]      p0_data,

   input  logic               p1_valid,
   output logic               p1_ready,
   input  logic [AW-1:0]      p1_addr,
   input  logic [DW-1:0]      p1_data,

   output logic               RegWrite,
   output logic [AW-1:0]      wr,
   output logic [DW-1:0]      wd,

   input  logic               iss_valid,
   input  logic [AW-1:0]      iss_rd,
   input  logic [AW-1:0]      chk_a,
   input  logic [AW-1:0]      chk_b,
   output logic               hz_a,
   output logic               hz_b,
   output logic [2**AW-1:0]   pend
);

   localparam int NREG = 2**AW;

   // -----------------------------------------------------------------------
   // Arbitration
   // -----------------------------------------------------------------------
   logic            grant0;
   logic            grant1;
   logic            xfer;
   logic [AW-1:0]   xfer_addr;
   logic [DW-1:0]   xfer_data;

`ifdef WBARB_RR_EN
   // last_q = 1 means port 1 was granted most recently, so port 0 wins the
   // next contention. The reset value of 1 therefore favours port 0 first.
   logic last_q;
   logic last_d;

   always_comb begin
      grant0 = p0_valid & (~p1_valid | last_q);
      grant1 = p1_valid & ~grant0;
   end

   // The pointer moves only on an actual transfer. While reset is asserted,
   // the readies are forced low, so no transfer can be recorded.
   always_comb begin
      last_d = last_q;
      if (p0_ready) begin
         last_d = 1'b0;
      end else if (p1_ready) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      grant0 = p0_valid;
      grant1 = p1_valid & ~p0_valid;
   end
`endif

   // The readies are purely combinational from the valids and the pointer.
   // They are held low while in reset, so nothing can be accepted.
   assign p0_ready = rst_n & grant0;
   assign p1_ready = rst_n & grant1;
   assign xfer     = p0_ready | p1_ready;

   always_comb begin
      xfer_addr = p1_addr;
      xfer_data = p1_data;
      if (p0_ready) begin
         xfer_addr = p0_addr;
         xfer_data = p0_data;
      end
   end

   // -----------------------------------------------------------------------
   // Output write-port register
   // -----------------------------------------------------------------------
   logic            regwrite_q;
   logic            regwrite_d;
   logic [AW-1:0]   wr_q;
   logic [AW-1:0]   wr_d;
   logic [DW-1:0]   wd_q;
   logic [DW-1:0]   wd_d;

   // An address-0 transfer is accepted and latched, but it never raises the
   // write enable, so register 0 is never written.
   always_comb begin
      regwrite_d = 1'b0;
      wr_d       = wr_q;
      wd_d       = wd_q;
      if (xfer) begin
         regwrite_d = (xfer_addr != '0);
         wr_d       = xfer_addr;
         wd_d       = xfer_data;
      end
   end

   // Asynchronous reset clears the staged write, so a write caught between
   // its grant and its write cycle is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_q <= 1'b0;
         wr_q       <= '0;
         wd_q       <= '0;
      end else begin
         regwrite_q <= regwrite_d;
         wr_q       <= wr_d;
         wd_q       <= wd_d;
      end
   end

   assign RegWrite = regwrite_q;
   assign wr       = wr_q;
   assign wd       = wd_q;

   // -----------------------------------------------------------------------
   // Pending-writeback scoreboard
   // -----------------------------------------------------------------------
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
         // Register 0 never has an outstanding writeback.
         assign pend_d[gi] = 1'b0;
      end else begin : g_bit
         logic set_bit;
         logic clr_bit;
         assign set_bit = iss_valid & (iss_rd == AW'(gi));
         assign clr_bit = xfer & (xfer_addr == AW'(gi));
         // A new issue on the same edge as the retiring writeback keeps the
         // bit set, because the younger instruction still owes a write.
         assign pend_d[gi] = set_bit | (pend_q[gi] & ~clr_bit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;

   // -----------------------------------------------------------------------
   // Hazard detection
   // -----------------------------------------------------------------------
   // A register stays hazardous through its RegWrite cycle, even though its
   // pend bit has already cleared. The value only reaches the file at the
   // end of that cycle.
   assign hz_a = (chk_a != '0) & (pend_q[chk_a] | (regwrite_q & (wr_q == chk_a)));
   assign hz_b = (chk_b != '0) & (pend_q[chk_b] | (regwrite_q & (wr_q == chk_b)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter. A behavioural model tracks the
// expected write port, the scoreboard and the arbitration pointer from the
// block's rules. Define WBARB_RR_EN for both the bench and the RTL to check
// the round-robin build.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 2**AW;

   logic            clk;
   logic            rst_n;
   logic            p0_valid, p0_ready;
   logic [AW-1:0]   p0_addr;
   logic [DW-1:0]   p0_data;
   logic            p1_valid, p1_ready;
   logic [AW-1:0]   p1_addr;
   logic [DW-1:0]   p1_data;
   logic            RegWrite;
   logic [AW-1:0]   wr;
   logic [DW-1:0]   wd;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic [AW-1:0]   chk_a, chk_b;
   logic            hz_a, hz_b;
   logic [NREG-1:0] pend;

   int vectors     = 0;
   int miscompares = 0;

   regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
      .RegWrite(RegWrite), .wr(wr), .wd(wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .chk_a(chk_a), .chk_b(chk_b), .hz_a(hz_a), .hz_b(hz_b),
      .pend(pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   bit              m_pend [NREG];
   bit              m_rw;
   int              m_wr;
   longint          m_wd;
   bit              m_known;     // m_wr/m_wd reflect a write the model can predict
   int              m_last;      // port granted most recently (round-robin build)
   bit              last_g0, last_g1;

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_rw = 0; m_wr = 0; m_wd = 0; m_known = 1; m_last = 1;
      last_g0 = 0; last_g1 = 0;
   endtask

   function automatic void model_grant(output bit g0, output bit g1);
      g0 = 0; g1 = 0;
      if (rst_n !== 1'b1) return;
      if (p0_valid && p1_valid) begin
`ifdef WBARB_RR_EN
         if (m_last == 0) g1 = 1; else g0 = 1;
`else
         g0 = 1;
`endif
      end else begin
         g0 = p0_valid;
         g1 = p1_valid;
      end
   endfunction

   function automatic bit model_hz(input int r);
      if (r == 0) return 0;
      return m_pend[r] || (m_rw && m_wr == r);
   endfunction

   function automatic logic [NREG-1:0] model_pend_vec();
      logic [NREG-1:0] v;
      for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Advance one clock and update the model from the inputs seen at the edge.
   task automatic tick();
      bit g0, g1;
      int a;
      longint d;
      model_grant(g0, g1);
      a = g0 ? int'(p0_addr) : int'(p1_addr);
      d = g0 ? longint'(p0_data) : longint'(p1_data);
      @(posedge clk);
      last_g0 = g0; last_g1 = g1;
      if (g0 || g1) begin
         m_rw = (a != 0);
         if (a != 0) begin m_wr = a; m_wd = d; m_known = 1; end
         else m_known = 0;
         m_pend[a] = 0;
         m_last = g0 ? 0 : 1;
      end else begin
         m_rw = 0;
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
      #1;
   endtask

   task automatic idle_inputs();
      p0_valid = 0; p0_addr = 0; p0_data = 0;
      p1_valid = 0; p1_addr = 0; p1_data = 0;
      iss_valid = 0; iss_rd = 0; chk_a = 0; chk_b = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      model_reset();
      p0_valid = 1; p1_valid = 1; p0_addr = 3; p1_addr = 4;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (RegWrite !== 1'b0 || wr !== '0 || wd !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got RegWrite=%b wr=%0d wd=%h, need 0/0/0", RegWrite, wr, wd);
      end
      vectors++;
      if (pend !== '0) begin
         miscompares++;
         $display("FAIL reset_pend: got %h, need 0", pend);
      end
      vectors++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got p0=%b p1=%b, need 0/0", p0_ready, p1_ready);
      end
      idle_inputs();
      rst_n = 1;
      $display("test_reset done");
   endtask

   task automatic test_single_write();
      do_reset();
      p0_valid = 1; p0_addr = 5; p0_data = 32'hDEADBEEF;
      #1;
      vectors++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_ready: got p0=%b p1=%b, need 1/0", p0_ready, p1_ready);
      end
      tick();
      p0_valid = 0;
      #1;
      vectors++;
      if (RegWrite !== 1'b1 || wr !== 5'd5 || wd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL single_write: got RegWrite=%b wr=%0d wd=%h, need 1/5/deadbeef", RegWrite, wr, wd);
      end
      tick();
      vectors++;
      if (RegWrite !== 1'b0 || wr !== 5'd5 || wd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL single_hold: got RegWrite=%b wr=%0d wd=%h, need 0/5/deadbeef", RegWrite, wr, wd);
      end
      $display("test_single_write done");
   endtask

   task automatic test_contention();
      bit exp0 [4];
`ifdef WBARB_RR_EN
      exp0 = '{1, 0, 1, 0};
`else
      exp0 = '{1, 1, 1, 1};
`endif
      do_reset();
      p0_valid = 1; p0_addr = 1; p0_data = 32'h1111_0000;
      p1_valid = 1; p1_addr = 2; p1_data = 32'h2222_0000;
      for (int c = 0; c < 4; c++) begin
         #1;
         vectors++;
         if (p0_ready !== exp0[c] || p1_ready !== !exp0[c]) begin
            miscompares++;
            $display("FAIL contention_grant[%0d]: got p0=%b p1=%b, need %b/%b",
                     c, p0_ready, p1_ready, exp0[c], !exp0[c]);
         end
         tick();
         vectors++;
         if (RegWrite !== 1'b1 || wr !== (exp0[c] ? 5'd1 : 5'd2)) begin
            miscompares++;
            $display("FAIL contention_write[%0d]: got RegWrite=%b wr=%0d, need 1/%0d",
                     c, RegWrite, wr, exp0[c] ? 1 : 2);
         end
      end
      idle_inputs();
      tick();
      $display("test_contention done");
   endtask

   task automatic test_zero_addr();
      p1_valid = 1; p1_addr = 0; p1_data = 32'h1234;
      #1;
      vectors++;
      if (p1_ready !== 1'b1 || p0_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_ready: got p0=%b p1=%b, need 0/1", p0_ready, p1_ready);
      end
      tick();
      p1_valid = 0;
      #1;
      vectors++;
      if (RegWrite !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_regwrite: got %b, need 0", RegWrite);
      end
      tick();
      vectors++;
      if (RegWrite !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_regwrite_after: got %b, need 0", RegWrite);
      end
      $display("test_zero_addr done");
   endtask

   task automatic test_hazard();
      do_reset();
      iss_valid = 1; iss_rd = 7;
      tick();
      iss_valid = 0; chk_a = 7; chk_b = 8;
      #1;
      vectors++;
      if (pend[7] !== 1'b1 || hz_a !== 1'b1 || hz_b !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_pending: got pend7=%b hz_a=%b hz_b=%b, need 1/1/0", pend[7], hz_a, hz_b);
      end
      p0_valid = 1; p0_addr = 7; p0_data = 32'hCAFE0007;
      tick();
      p0_valid = 0;
      #1;
      vectors++;
      if (pend[7] !== 1'b0 || hz_a !== 1'b1 || RegWrite !== 1'b1) begin
         miscompares++;
         $display("FAIL hazard_wb_cycle: got pend7=%b hz_a=%b RegWrite=%b, need 0/1/1", pend[7], hz_a, RegWrite);
      end
      tick();
      vectors++;
      if (hz_a !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_clear: got hz_a=%b, need 0", hz_a);
      end
      chk_a = 0;
      iss_valid = 1; iss_rd = 0;
      tick();
      iss_valid = 0;
      #1;
      vectors++;
      if (pend !== '0 || hz_a !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_reg0: got pend=%h hz_a=%b, need 0/0", pend, hz_a);
      end
      $display("test_hazard done");
   endtask

   task automatic test_set_clear();
      do_reset();
      iss_valid = 1; iss_rd = 9;
      tick();
      p0_valid = 1; p0_addr = 9; p0_data = 32'h99;
      tick();
      iss_valid = 0; p0_valid = 0;
      #1;
      vectors++;
      if (pend[9] !== 1'b1) begin
         miscompares++;
         $display("FAIL set_wins: got pend9=%b, need 1", pend[9]);
      end
      p1_valid = 1; p1_addr = 9; p1_data = 32'h999;
      tick();
      p1_valid = 0;
      #1;
      vectors++;
      if (pend[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL set_then_clear: got pend9=%b, need 0", pend[9]);
      end
      $display("test_set_clear done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      iss_valid = 1; iss_rd = 3;
      tick();
      iss_valid = 0;
      p0_valid = 1; p0_addr = 3; p0_data = 32'h3333;
      tick();
      p0_valid = 0;
      rst_n = 0;
      model_reset();
      #1;
      vectors++;
      if (RegWrite !== 1'b0 || pend !== '0) begin
         miscompares++;
         $display("FAIL midreset_async: got RegWrite=%b pend=%h, need 0/0", RegWrite, pend);
      end
      #2 rst_n = 1;
      tick();
      vectors++;
      if (RegWrite !== 1'b0 || pend !== '0) begin
         miscompares++;
         $display("FAIL midreset_after: got RegWrite=%b pend=%h, need 0/0", RegWrite, pend);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      bit g0, g1;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         // A requester keeps its request stable until it has been granted.
         if (!p0_valid || last_g0) begin
            p0_valid = ($urandom_range(0, 2) != 0);
            p0_addr  = AW'($urandom_range(0, 7));
            p0_data  = $urandom;
         end
         if (!p1_valid || last_g1) begin
            p1_valid = ($urandom_range(0, 2) != 0);
            p1_addr  = AW'($urandom_range(0, 7));
            p1_data  = $urandom;
         end
         iss_valid = $urandom_range(0, 1);
         iss_rd    = AW'($urandom_range(0, 7));
         chk_a     = AW'($urandom_range(0, 7));
         chk_b     = AW'($urandom_range(0, 7));
         #1;
         model_grant(g0, g1);
         vectors++;
         if (p0_ready !== g0 || p1_ready !== g1) begin
            miscompares++;
            $display("FAIL rand_ready[%0d]: got p0=%b p1=%b, need %b/%b", c, p0_ready, p1_ready, g0, g1);
         end
         vectors++;
         if (hz_a !== model_hz(int'(chk_a)) || hz_b !== model_hz(int'(chk_b))) begin
            miscompares++;
            $display("FAIL rand_hz[%0d]: got hz_a=%b hz_b=%b, need %b/%b",
                     c, hz_a, hz_b, model_hz(int'(chk_a)), model_hz(int'(chk_b)));
         end
         tick();
         vectors++;
         if (RegWrite !== m_rw || (m_known && (int'(wr) != m_wr || longint'(wd) != m_wd))) begin
            miscompares++;
            $display("FAIL rand_wport[%0d]: got RegWrite=%b wr=%0d wd=%h, need %b/%0d/%h",
                     c, RegWrite, wr, wd, m_rw, m_wr, m_wd);
         end
         vectors++;
         if (pend !== model_pend_vec()) begin
            miscompares++;
            $display("FAIL rand_pend[%0d]: got %h, need %h", c, pend, model_pend_vec());
         end
      end
      idle_inputs();
      $display("test_random done");
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      model_reset();
      test_reset();
      test_single_write();
      test_contention();
      test_zero_addr();
      test_hazard();
      test_set_clear();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DW, default 32: write-data width.
REQ-002 Parameter AW, default 5: register address width; the register count is 2**AW.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port p0_valid, input, 1 bit: requester 0 has a writeback pending.
REQ-006 Port p0_ready, output, 1 bit: requester 0 is granted this cycle.
REQ-007 Port p0_addr, input, AW bits: requester 0 destination register.
REQ-008 Port p0_data, input, DW bits: requester 0 write data.
REQ-009 Ports p1_valid, p1_ready, p1_addr and p1_data: identical to the p0_* ports, for requester 1.
REQ-010 Port RegWrite, output, 1 bit: register-file write enable.
REQ-011 Port wr, output, AW bits: register-file write address.
REQ-012 Port wd, output, DW bits: register-file write data.
REQ-013 Port iss_valid, input, 1 bit: an instruction issued with a destination register.
REQ-014 Port iss_rd, input, AW bits: destination register of the issued instruction.
REQ-015 Ports chk_a and chk_b, input, AW bits each: source registers to hazard-check.
REQ-016 Ports hz_a and hz_b, output, 1 bit each: a hazard exists on chk_a or chk_b respectively.
REQ-017 Port pend, output, 2**AW bits: scoreboard of registers with a writeback outstanding.

Function
REQ-018 Handshake: a transfer occurs on a rising edge where px_valid and px_ready are both 1; a requester SHALL hold valid, addr and data stable until it is granted.
REQ-019 px_ready SHALL be combinational from the valid inputs and the arbitration state only; the write port never back-pressures.
REQ-020 At most one of p0_ready and p1_ready SHALL be 1 in any cycle; a lone valid requester is granted in the same cycle.
REQ-021 A granted transfer SHALL appear on the outputs one cycle later as RegWrite=1, wr=addr, wd=data, held for exactly one cycle.
REQ-022 A cycle with no transfer SHALL produce RegWrite=0 on the next cycle, with wr and wd holding their last values.
REQ-023 A transfer with addr=0 SHALL be accepted normally but SHALL produce RegWrite=0 (register 0 is never written).
REQ-024 pend[r] SHALL set on an edge with iss_valid=1, iss_rd=r and r≠0, and SHALL clear on the edge of a granted transfer to r.
REQ-025 When a set and a clear of the same bit occur on one edge, the set SHALL win.
REQ-026 pend[0] SHALL always be 0.
REQ-027 hz_a SHALL equal pend[chk_a] OR (RegWrite AND wr==chk_a), forced to 0 when chk_a=0 (combinational); hz_b is the same function of chk_b.
REQ-028 Arbitration SHALL follow the Configuration section when both requesters are valid.

Reset
REQ-029 While rst_n=0, the block SHALL hold RegWrite=0, wr=0, wd=0, pend=0, and the round-robin pointer (if present) at 1.
REQ-030 Assertion of rst_n SHALL take effect immediately, without a clock; release SHALL be synchronous to clk.
REQ-031 A reset arriving mid-operation SHALL discard any write held in the output register; the write SHALL NOT occur after release.
REQ-032 While rst_n=0, p0_ready and p1_ready SHALL be 0.

Configuration
REQ-033 With WBARB_RR_EN defined, a 1-bit last-grant pointer SHALL record the most recently granted port; on contention the other port wins; the pointer SHALL update only on a granted transfer.
REQ-034 With WBARB_RR_EN undefined, port 0 SHALL always win on contention; there is no pointer state and port 1 may starve.

Verification
REQ-035 Reset release, p0_valid=1, p0_addr=5, p0_data=0xDEADBEEF -> p0_ready=1 the same cycle; the next cycle has RegWrite=1, wr=5, wd=0xDEADBEEF, and the cycle after has RegWrite=0.
REQ-036 Both ports valid for 4 cycles (p0 to reg 1, p1 to reg 2) with RR enabled -> grant order p0, p1, p0, p1; with RR disabled -> p0 granted in all 4 cycles.
REQ-037 p1 transfer to addr=0 with data 0x1234 -> p1_ready=1, RegWrite stays 0, no register change.
REQ-038 iss_valid with iss_rd=7 -> pend[7]=1 and hz_a=1 for chk_a=7; after the grant to reg 7, pend[7]=0 but hz_a stays 1 during the RegWrite cycle, then drops to 0.
REQ-039 iss_valid with iss_rd=9 on the same edge as a grant to reg 9 -> pend[9] remains 1.
REQ-040 rst_n pulsed low between a grant and its write cycle -> RegWrite never asserts and pend returns to 0.
